// File: rtl/jtvigil_ba0_pkg.sv
// Shared types and defaults for the bank-0 ROM arbiter.
package jtvigil_ba0_pkg;

  localparam int unsigned BA_AW = 22;
  localparam int unsigned NSLOT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ID_MAIN = 2'd0,
    ID_SND  = 2'd1,
    ID_PCM  = 2'd2
  } req_id_t;

  localparam logic [BA_AW-1:0] MAIN_OFFSET_DEF = 22'h00000;
  localparam logic [BA_AW-1:0] SND_OFFSET_DEF  = 22'h20000;
  localparam logic [BA_AW-1:0] PCM_OFFSET_DEF  = 22'h28000;

  // Round-robin successor: main -> snd -> pcm -> main.
  function automatic req_id_t next_id(input req_id_t id);
    case (id)
      ID_MAIN: next_id = ID_SND;
      ID_SND:  next_id = ID_PCM;
      default: next_id = ID_MAIN;
    endcase
  endfunction

endpackage

// File: rtl/jtvigil_ba0_slot.sv
// One-word read cache for a single byte-wide ROM requester.
module jtvigil_ba0_slot
  import jtvigil_ba0_pkg::*;
#(
  parameter int unsigned       AW     = 16,
  parameter logic [BA_AW-1:0]  OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             downloading,
  input  logic             cs,
  input  logic [AW-1:0]    addr,
  input  logic             grant,
  input  logic             fill,
  input  logic [15:0]      fill_word,
  output logic             ok_c,
  output logic             miss_c,
  output logic [7:0]       data_c,
  output logic [BA_AW-1:0] word_addr_c
);

  localparam int unsigned TW = AW - 1;

  logic [TW-1:0] tag;
  logic [TW-1:0] pend_tag;
  logic [15:0]   word;
  logic          valid;
  logic [7:0]    last_byte;
  logic          hit;
  logic [7:0]    sel_byte;

  // Hit detection, byte select and the SDRAM word address for this slot.
  always_comb begin
    hit         = valid && (tag == addr[AW-1:1]);
    ok_c        = cs && hit;
    miss_c      = cs && !hit;
    sel_byte    = addr[0] ? word[15:8] : word[7:0];
    data_c      = ok_c ? sel_byte : last_byte;
    word_addr_c = BA_AW'(addr[AW-1:1]) + OFFSET;
  end

  // Cache storage: tag captured at grant, word/tag committed at fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag       <= '0;
      pend_tag  <= '0;
      word      <= '0;
      valid     <= 1'b0;
      last_byte <= '0;
    end else begin
      if (grant) pend_tag <= addr[AW-1:1];
      if (fill) begin
        word  <= fill_word;
        tag   <= pend_tag;
        valid <= !downloading;
      end else if (downloading) begin
        valid <= 1'b0;
      end
      if (ok_c) last_byte <= sel_byte;
    end
  end

endmodule

// File: rtl/jtvigil_ba0_arb.sv
// Round-robin sharing of SDRAM bank 0 between main, sound and PCM ROM readers.
module jtvigil_ba0_arb
  import jtvigil_ba0_pkg::*;
#(
  parameter int unsigned      MAIN_AW     = 18,
  parameter int unsigned      SND_AW      = 16,
  parameter int unsigned      PCM_AW      = 16,
  parameter logic [BA_AW-1:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
  parameter logic [BA_AW-1:0] SND_OFFSET  = SND_OFFSET_DEF,
  parameter logic [BA_AW-1:0] PCM_OFFSET  = PCM_OFFSET_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic               main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic               snd_cs,
  input  logic [SND_AW-1:0]  snd_addr,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  input  logic               pcm_cs,
  input  logic [PCM_AW-1:0]  pcm_addr,
  output logic [7:0]         pcm_data,
  output logic               pcm_ok,
  output logic [BA_AW-1:0]   ba0_addr,
  output logic               ba0_rd,
  input  logic               ba0_ack,
  input  logic               ba0_rdy,
  input  logic [15:0]        data_read
);

  state_t           state, state_d;
  req_id_t          ptr, ptr_d;
  req_id_t          gnt, gnt_d;
  logic             ba0_rd_d;
  logic [BA_AW-1:0] ba0_addr_d;

  logic [NSLOT-1:0] miss_c;
  logic [NSLOT-1:0] grant_c;
  logic [NSLOT-1:0] fill_c;
  logic [BA_AW-1:0] waddr_c [NSLOT];

  logic             found_c;
  req_id_t          pick_c;
  req_id_t          cand_c;

  jtvigil_ba0_slot #(.AW(MAIN_AW), .OFFSET(MAIN_OFFSET)) u_main (
    .clk(clk), .rst(rst), .downloading(downloading),
    .cs(main_cs), .addr(main_addr),
    .grant(grant_c[ID_MAIN]), .fill(fill_c[ID_MAIN]), .fill_word(data_read),
    .ok_c(main_ok), .miss_c(miss_c[ID_MAIN]), .data_c(main_data),
    .word_addr_c(waddr_c[ID_MAIN])
  );

  jtvigil_ba0_slot #(.AW(SND_AW), .OFFSET(SND_OFFSET)) u_snd (
    .clk(clk), .rst(rst), .downloading(downloading),
    .cs(snd_cs), .addr(snd_addr),
    .grant(grant_c[ID_SND]), .fill(fill_c[ID_SND]), .fill_word(data_read),
    .ok_c(snd_ok), .miss_c(miss_c[ID_SND]), .data_c(snd_data),
    .word_addr_c(waddr_c[ID_SND])
  );

  jtvigil_ba0_slot #(.AW(PCM_AW), .OFFSET(PCM_OFFSET)) u_pcm (
    .clk(clk), .rst(rst), .downloading(downloading),
    .cs(pcm_cs), .addr(pcm_addr),
    .grant(grant_c[ID_PCM]), .fill(fill_c[ID_PCM]), .fill_word(data_read),
    .ok_c(pcm_ok), .miss_c(miss_c[ID_PCM]), .data_c(pcm_data),
    .word_addr_c(waddr_c[ID_PCM])
  );

  // First missing slot at or after the round-robin pointer.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr;
    cand_c  = ptr;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (!found_c && miss_c[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
      cand_c = next_id(cand_c);
    end
  end

  // Next-state and handshake control; a started SDRAM read always runs to completion.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    gnt_d      = gnt;
    ba0_rd_d   = ba0_rd;
    ba0_addr_d = ba0_addr;
    grant_c    = '0;
    fill_c     = '0;
    case (state)
      ST_IDLE: begin
        if (!downloading && found_c) begin
          grant_c[pick_c] = 1'b1;
          gnt_d           = pick_c;
          ba0_addr_d      = waddr_c[pick_c];
          ba0_rd_d        = 1'b1;
          state_d         = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ba0_ack) begin
          ba0_rd_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ba0_rdy) begin
          fill_c[gnt] = 1'b1;
          ptr_d       = next_id(gnt);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        ba0_rd_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, pointer and bank-0 request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= ID_MAIN;
      gnt      <= ID_MAIN;
      ba0_rd   <= 1'b0;
      ba0_addr <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      gnt      <= gnt_d;
      ba0_rd   <= ba0_rd_d;
      ba0_addr <= ba0_addr_d;
    end
  end

endmodule

// File: tb/tb_jtvigil_ba0_arb.sv
// Directed bench for jtvigil_ba0_arb with a transaction-level cache model.
module tb_jtvigil_ba0_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic        main_cs, snd_cs, pcm_cs;
  logic [17:0] main_addr;
  logic [15:0] snd_addr, pcm_addr;
  logic [7:0]  main_data, snd_data, pcm_data;
  logic        main_ok, snd_ok, pcm_ok;
  logic [21:0] ba0_addr;
  logic        ba0_rd;
  logic        ba0_ack, ba0_rdy;
  logic [15:0] data_read;

  int checks   = 0;
  int failures = 0;

  int ack_dly = 2;
  int rdy_dly = 2;

  jtvigil_ba0_arb dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  // SDRAM contents seen by the bench.
  function automatic logic [15:0] mem(input logic [21:0] a);
    if (a == 22'h2) return 16'hA55A;
    return a[15:0] ^ 16'h3C3C;
  endfunction

  // Bank-0 responder: ack after ack_dly cycles, data rdy_dly cycles after ack.
  initial begin
    logic [21:0] a;
    ba0_ack   = 1'b0;
    ba0_rdy   = 1'b0;
    data_read = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && ba0_rd) begin
        a = ba0_addr;
        for (int i = 1; i < ack_dly; i++) begin @(posedge clk); #1; end
        ba0_ack = 1'b1;
        @(posedge clk); #1;
        ba0_ack = 1'b0;
        for (int i = 1; i < rdy_dly; i++) begin @(posedge clk); #1; end
        ba0_rdy   = 1'b1;
        data_read = mem(a);
        @(posedge clk); #1;
        ba0_rdy   = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  string       nm [3] = '{"main", "snd", "pcm"};
  int unsigned off [3] = '{32'h00000, 32'h20000, 32'h28000};
  bit          mv [3];
  int unsigned mtag [3];
  logic [15:0] mword [3];
  logic [7:0]  mlast [3];
  int          mptr;
  bit          pend, acc;
  int          pslot;
  int unsigned ptag;
  logic [21:0] maddr;
  logic        prev_rd = 1'b0;
  logic [21:0] reqs [$];

  function automatic bit cs_of(input int s);
    case (s) 0: return main_cs; 1: return snd_cs; default: return pcm_cs; endcase
  endfunction
  function automatic int unsigned addr_of(input int s);
    case (s) 0: return 32'(main_addr); 1: return 32'(snd_addr); default: return 32'(pcm_addr); endcase
  endfunction
  function automatic logic ok_of(input int s);
    case (s) 0: return main_ok; 1: return snd_ok; default: return pcm_ok; endcase
  endfunction
  function automatic logic [7:0] data_of(input int s);
    case (s) 0: return main_data; 1: return snd_data; default: return pcm_data; endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model across the coming edge.
  task automatic model_step();
    logic [7:0]  eb  [3];
    bit          eok [3];
    int unsigned a;
    bit          found;
    int          c, pick;
    if (!rst) begin
      for (int s = 0; s < 3; s++) begin
        mv[s] = 0; mtag[s] = 0; mword[s] = '0; mlast[s] = '0;
      end
      mptr = 0; pend = 0; acc = 0; pslot = 0; ptag = 0; maddr = '0;
    end
    if (ba0_rd && !prev_rd) reqs.push_back(ba0_addr);
    prev_rd = ba0_rd;
    for (int s = 0; s < 3; s++) begin
      a      = addr_of(s);
      eb[s]  = a[0] ? mword[s][15:8] : mword[s][7:0];
      eok[s] = cs_of(s) && mv[s] && (mtag[s] == (a >> 1));
      check({nm[s], "_ok"}, 32'(ok_of(s)), 32'(eok[s]));
      check({nm[s], "_data"}, 32'(data_of(s)), 32'(eok[s] ? eb[s] : mlast[s]));
    end
    check("ba0_rd", 32'(ba0_rd), 32'(pend && !acc));
    check("ba0_addr", 32'(ba0_addr), 32'(maddr));
    if (rst) begin
      for (int s = 0; s < 3; s++) if (eok[s]) mlast[s] = eb[s];
      if (!pend) begin
        if (!downloading) begin
          found = 0; c = mptr; pick = 0;
          for (int k = 0; k < 3; k++) begin
            if (!found && cs_of(c) && !eok[c]) begin found = 1; pick = c; end
            c = (c + 1) % 3;
          end
          if (found) begin
            pend  = 1; acc = 0; pslot = pick;
            ptag  = addr_of(pick) >> 1;
            maddr = 22'(ptag + off[pick]);
          end
        end
      end else if (!acc) begin
        if (ba0_ack) acc = 1;
      end else if (ba0_rdy) begin
        mword[pslot] = data_read;
        mtag[pslot]  = ptag;
        mv[pslot]    = !downloading;
        mptr         = (pslot + 1) % 3;
        pend         = 0;
      end
      if (downloading) for (int s = 0; s < 3; s++) mv[s] = 0;
    end
  endtask

  task automatic edge_drv();
    @(posedge clk); #1;
  endtask
  task automatic sample();
    @(negedge clk);
    model_step();
  endtask
  task automatic cyc();
    edge_drv();
    sample();
  endtask

  task automatic wait_ok(input int s);
    int n = 0;
    while (!ok_of(s) && n < 200) begin cyc(); n++; end
    if (n >= 200) check({"timeout_", nm[s], "_ok"}, 32'(ok_of(s)), 32'd1);
  endtask
  task automatic wait_all();
    int n = 0;
    while (!(main_ok && snd_ok && pcm_ok) && n < 300) begin cyc(); n++; end
    if (n >= 300) check("timeout_all_ok", 32'(main_ok && snd_ok && pcm_ok), 32'd1);
  endtask
  task automatic wait_reqs(input int cnt);
    int n = 0;
    while (reqs.size() < cnt && n < 200) begin cyc(); n++; end
    if (n >= 200) check("timeout_req", 32'(reqs.size()), 32'(cnt));
  endtask
  task automatic wait_ack();
    int n = 0;
    while (!ba0_ack && n < 200) begin cyc(); n++; end
    if (n >= 200) check("timeout_ack", 32'(ba0_ack), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0; downloading = 1'b0;
    main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    main_addr = '0; snd_addr = '0; pcm_addr = '0;

    // Reset state
    sample();
    check("rst_ba0_rd", 32'(ba0_rd), 32'd0);
    check("rst_ba0_addr", 32'(ba0_addr), 32'd0);
    check("rst_main_data", 32'(main_data), 32'd0);
    cyc();
    edge_drv(); rst = 1'b1; sample();

    // Main miss, then a hit on the other byte of the same word
    edge_drv(); main_cs = 1'b1; main_addr = 18'h00005; sample();
    wait_ok(0);
    check("t1_req_addr", 32'(reqs[0]), 32'h00002);
    check("t1_main_data", 32'(main_data), 32'hA5);
    edge_drv(); main_addr = 18'h00004; sample();
    check("t1_hit_ok", 32'(main_ok), 32'd1);
    check("t1_hit_data", 32'(main_data), 32'h5A);
    check("t1_no_new_req", 32'(reqs.size()), 32'd1);

    // Sound and PCM offsets
    edge_drv(); main_cs = 1'b0; snd_cs = 1'b1; snd_addr = 16'h0010; sample();
    wait_ok(1);
    check("t2_snd_addr", 32'(reqs[1]), 32'h20008);
    check("t2_snd_data", 32'(snd_data), 32'h34);
    edge_drv(); snd_cs = 1'b0; pcm_cs = 1'b1; pcm_addr = 16'hFFFF; sample();
    wait_ok(2);
    check("t2_pcm_addr", 32'(reqs[2]), 32'h2FFFF);
    check("t2_pcm_data", 32'(pcm_data), 32'hC3);

    // Three simultaneous misses, pointer at main
    edge_drv();
    main_cs = 1'b1; main_addr = 18'h10;
    snd_cs  = 1'b1; snd_addr  = 16'h20;
    pcm_cs  = 1'b1; pcm_addr  = 16'h30;
    sample();
    wait_all();
    check("t3a_first", 32'(reqs[3]), 32'h00008);
    check("t3a_second", 32'(reqs[4]), 32'h20010);
    check("t3a_third", 32'(reqs[5]), 32'h28018);
    // Move the pointer to snd with a lone main fill, then repeat
    edge_drv(); main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0; sample();
    edge_drv(); main_cs = 1'b1; main_addr = 18'h40; sample();
    wait_ok(0);
    check("t3_main_solo", 32'(reqs[6]), 32'h00020);
    edge_drv();
    main_addr = 18'h50;
    snd_cs = 1'b1; snd_addr = 16'h60;
    pcm_cs = 1'b1; pcm_addr = 16'h70;
    sample();
    wait_all();
    check("t3b_first", 32'(reqs[7]), 32'h20030);
    check("t3b_second", 32'(reqs[8]), 32'h28038);
    check("t3b_third", 32'(reqs[9]), 32'h00028);

    // Address change while the request is outstanding
    edge_drv(); main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0; sample();
    base = reqs.size();
    edge_drv(); main_cs = 1'b1; main_addr = 18'h100; sample();
    wait_reqs(base + 1);
    edge_drv(); main_addr = 18'h200; sample();
    wait_reqs(base + 2);
    check("t4_stale_ok", 32'(main_ok), 32'd0);
    check("t4_first_req", 32'(reqs[base]), 32'h00080);
    check("t4_second_req", 32'(reqs[base+1]), 32'h00100);
    wait_ok(0);
    check("t4_data", 32'(main_data), 32'h3C);

    // Download starting while a read is in flight
    edge_drv(); main_cs = 1'b0; sample();
    rdy_dly = 4;
    base = reqs.size();
    edge_drv();
    main_cs = 1'b1; main_addr = 18'h300;
    snd_cs  = 1'b1; snd_addr  = 16'h60;
    pcm_cs  = 1'b1; pcm_addr  = 16'h70;
    sample();
    check("t5_snd_hit_before", 32'(snd_ok), 32'd1);
    check("t5_pcm_hit_before", 32'(pcm_ok), 32'd1);
    wait_ack();
    edge_drv(); downloading = 1'b1; sample();
    for (int i = 0; i < 3; i++) cyc();
    check("t5_snd_ok_dl", 32'(snd_ok), 32'd0);
    check("t5_pcm_ok_dl", 32'(pcm_ok), 32'd0);
    for (int i = 0; i < 7; i++) cyc();
    check("t5_main_ok_dl", 32'(main_ok), 32'd0);
    check("t5_no_req_dl", 32'(reqs.size()), 32'(base + 1));
    check("t5_rd_dl", 32'(ba0_rd), 32'd0);
    edge_drv(); downloading = 1'b0; sample();
    wait_all();
    check("t5_req0", 32'(reqs[base]), 32'h00180);
    check("t5_req1", 32'(reqs[base+1]), 32'h20030);
    check("t5_req2", 32'(reqs[base+2]), 32'h28038);
    check("t5_req3", 32'(reqs[base+3]), 32'h00180);

    // Reset while the request is waiting for ack
    rdy_dly = 2;
    ack_dly = 5;
    edge_drv(); main_cs = 1'b0; pcm_cs = 1'b0; sample();
    base = reqs.size();
    edge_drv(); main_cs = 1'b1; main_addr = 18'h400; sample();
    wait_reqs(base + 1);
    check("t6_req", 32'(reqs[base]), 32'h00200);
    check("t6_snd_ok_pre", 32'(snd_ok), 32'd1);
    edge_drv(); rst = 1'b0; sample();
    check("t6_rd_rst", 32'(ba0_rd), 32'd0);
    check("t6_addr_rst", 32'(ba0_addr), 32'd0);
    check("t6_snd_ok_rst", 32'(snd_ok), 32'd0);
    check("t6_snd_data_rst", 32'(snd_data), 32'd0);
    edge_drv(); rst = 1'b1; main_cs = 1'b0; snd_cs = 1'b0; sample();
    for (int i = 0; i < 15; i++) cyc();
    edge_drv(); main_cs = 1'b1; sample();
    check("t6_no_fill", 32'(main_ok), 32'd0);
    check("t6_no_req", 32'(reqs.size()), 32'(base + 1));
    wait_ok(0);
    check("t6_refetch_data", 32'(main_data), 32'h3C);
    for (int i = 0; i < 4; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtvigil_ba0_arb.md
Name: jtvigil_ba0_arb

Overview:
Shares SDRAM bank 0 between three byte-wide ROM requesters: main CPU ROM, sound CPU ROM and PCM ROM. Each requester gets a one-word read cache, and misses are serviced by a round-robin scheduler driving the bank-0 read handshake. It sits inside the game SDRAM glue and replaces per-requester direct bank access. Bank 0 is read-only here.

Parameters:
MAIN_AW, 18, main byte address width
SND_AW, 16, sound CPU byte address width
PCM_AW, 16, PCM byte address width
MAIN_OFFSET, 22'h00000, word offset of main ROM in bank 0
SND_OFFSET, 22'h20000, word offset of sound ROM
PCM_OFFSET, 22'h28000, word offset of PCM ROM

Ports:
- Clock and reset:
  - clk  in  1  SDRAM clock
  - rst  in  1  asynchronous reset, active-low
- Control:
  - downloading  in  1  ROM load in progress
- Main requester:
  - main_cs  in  1  main read request
  - main_addr  in  MAIN_AW  main byte address
  - main_data  out  8  main read data
  - main_ok  out  1  main data valid
- Sound requester:
  - snd_cs  in  1  sound read request
  - snd_addr  in  SND_AW  sound byte address
  - snd_data  out  8  sound read data
  - snd_ok  out  1  sound data valid
- PCM requester:
  - pcm_cs  in  1  PCM read request
  - pcm_addr  in  PCM_AW  PCM byte address
  - pcm_data  out  8  PCM read data
  - pcm_ok  out  1  PCM data valid
- SDRAM bank 0:
  - ba0_addr  out  22  bank-0 word address
  - ba0_rd  out  1  read request
  - ba0_ack  in  1  request accepted
  - ba0_rdy  in  1  data_read valid this cycle
  - data_read  in  16  SDRAM read word

Behaviour:
Reset:
- rst low clears all three cache valid bits.
- ba0_rd=0, ba0_addr=0, state=IDLE, round-robin pointer=main.
- All *_ok=0 and *_data=0 on reset.

Per-slot cache:
- Each slot holds a 16-bit word, a tag (word address = addr[AW-1:1]) and a valid bit.
- hit = valid & tag==addr[AW-1:1].
- x_ok = x_cs & hit, combinational from registers and inputs, so zero-cycle hit latency.
- x_data selects the byte from addr[0]: 1 gives [15:8], 0 gives [7:0]. It is combinational and holds the last selected byte when ok is low.
- miss = x_cs & ~hit.

FSM (IDLE, REQ, WAIT):
- IDLE:
  - Idles if downloading=1 or there is no miss.
  - Otherwise grants the first missing slot after the pointer, in order main→snd→pcm→main.
  - Registers ba0_addr = slot word address + slot OFFSET, truncated to 22 bits, and sets ba0_rd=1.
  - Latches grant id and tag, then goes to REQ.
- REQ:
  - Holds ba0_rd and ba0_addr stable until ba0_ack.
  - On ba0_ack: ba0_rd=0, go to WAIT.
- WAIT:
  - On ba0_rdy: writes data_read and the latched tag into the granted slot.
  - Sets valid=1 unless downloading=1.
  - Pointer moves to the slot after the grant. Go to IDLE.

Timing and boundary conditions:
- Miss latency: cs at cycle 0 → ba0_rd at cycle 1 → ok the cycle after the ba0_rdy edge.
- Requester drops cs or changes addr mid-transaction: the transaction still completes, since SDRAM cannot be aborted, and fills the latched tag. A changed addr then misses and issues a new request.
- ba0_ack and ba0_rdy in the same cycle while in REQ: treated as ack only. rdy is honoured only in WAIT.
- downloading rising: all valid bits clear that cycle and no new grants are made. An in-flight read completes but does not set valid.
- All three miss simultaneously: served in pointer order, one each, with no starvation. The worst-case wait is two transactions.
- Reset mid-transaction: immediately returns to IDLE with ba0_rd=0. Any late ba0_ack or ba0_rdy is ignored outside REQ/WAIT.

Decomposition:
- Package jtvigil_ba0_pkg holds:
  - state encoding (IDLE/REQ/WAIT);
  - requester ids (MAIN=0, SND=1, PCM=2);
  - the default offsets.
- Sub-module jtvigil_ba0_slot, instantiated 3×, parameterised by AW and OFFSET. It holds the cache word, tag and valid bit, and produces hit, ok, data and the offset word address.

Test Plan:
1. Reset, then main_cs=1, main_addr=18'h00005, SDRAM model returning 16'hA55A with ack at +2 and rdy at +4 → ba0_addr=22'h00002; main_data=8'hA5 and main_ok=1 after rdy; a later access to addr 18'h00004 hits at once with data 8'h5A and no ba0_rd.
2. snd_cs, snd_addr=16'h0010 → ba0_addr=22'h20008. pcm_cs, pcm_addr=16'hFFFF → ba0_addr=22'h2FFFF, pcm_data returns the upper byte.
3. All three cs missing at cycle 0, pointer=main → grants in order main, snd, pcm. Repeated with pointer=snd → order snd, pcm, main.
4. main_addr changes from 18'h100 to 18'h200 while in REQ → the first fill is tag 0x80 with main_ok=0. A second request goes to 22'h100, then main_ok=1.
5. downloading pulsed high while in WAIT → the fill does not set valid, all slots read ok=0, and no ba0_rd is issued while downloading=1.
6. rst asserted low while in REQ → ba0_rd=0 and all ok=0 immediately. A stray ba0_rdy afterwards causes no fill.
